tag_resolver: RTL and testbench

TAG_RESOLVER -- requirements
Module: tag_resolver

---
 rtl/tag_resolver.sv | 195 +++++++++++++++++++
 tb/tb_tag_resolver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_resolver.sv
// tag_resolver: tag vector register, match iterator and optional population count
// for a CAM cell array.
//
// Build option: define TAG_RESOLVER_COUNT_EN to compile in the COUNT state,
// the tag snapshot and the serial bit counter. Without it, op 7 is a no-op,
// op_ready is constant 1 and match_count/count_valid are tied to 0.
//
// Ports:
//   clk          sole clock, rising edge
//   rstIn        asynchronous, active-high reset
//   tag_row      per-row match result from the cell array compare
//   op_valid     operation request strobe
//   op           0 NEXT, 1 LOAD, 2 AND, 3 OR, 4 CLR, 5 SET, 6 FIRST, 7 COUNT
//   op_ready     operation can be accepted this cycle
//   tag          registered tag vector (cell array write-enable)
//   any_match    OR-reduction of tag
//   match_addr   current iterator row address
//   match_valid  match_addr refers to a tagged row
//   match_count  set-bit count of tag captured at the last completed COUNT
//   count_valid  one-cycle pulse when match_count updates
module tag_resolver #(
    parameter int unsigned DATA_DEPTH     = 16,
    parameter int unsigned ADDR_WIDTH_CAM = 8
) (
    input  logic                      clk,
    input  logic                      rstIn,
    input  logic [DATA_DEPTH-1:0]     tag_row,
    input  logic                      op_valid,
    input  logic [2:0]                op,
    output logic                      op_ready,
    output logic [DATA_DEPTH-1:0]     tag,
    output logic                      any_match,
    output logic [ADDR_WIDTH_CAM-1:0] match_addr,
    output logic                      match_valid,
    output logic [ADDR_WIDTH_CAM:0]   match_count,
    output logic                      count_valid
);

    localparam int unsigned CNT_W = ADDR_WIDTH_CAM + 1;

    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;
    localparam logic [2:0] OP_SET   = 3'd5;
    localparam logic [2:0] OP_FIRST = 3'd6;
    localparam logic [2:0] OP_COUNT = 3'd7;

    logic                  accept;
    logic [DATA_DEPTH-1:0] iter_mask;
    logic [DATA_DEPTH-1:0] iter_src;
    logic                  iter_load;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [ADDR_WIDTH_CAM-1:0] lowest_set(input logic [DATA_DEPTH-1:0] v);
        logic [ADDR_WIDTH_CAM-1:0] idx;
        idx = '0;
        for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ADDR_WIDTH_CAM'(i);
            end
        end
        return idx;
    endfunction

    assign accept    = op_valid & op_ready;
    assign any_match = |tag;

    // Tag register; only the set-algebra ops touch it.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            tag <= '0;
        end else if (accept) begin
            case (op)
                OP_LOAD: tag <= tag_row;
                OP_AND:  tag <= tag & tag_row;
                OP_OR:   tag <= tag | tag_row;
                OP_CLR:  tag <= '0;
                OP_SET:  tag <= '1;
                default: tag <= tag;
            endcase
        end
    end

    // Iterator update source: FIRST reloads from tag, NEXT retires the reported row.
    // NEXT with nothing valid leaves the iterator untouched.
    always_comb begin
        iter_load = 1'b0;
        iter_src  = iter_mask;
        if (accept) begin
            if (op == OP_FIRST) begin
                iter_load = 1'b1;
                iter_src  = tag;
            end else if (op == OP_NEXT && match_valid) begin
                iter_load = 1'b1;
                iter_src  = iter_mask & ~(DATA_DEPTH'(1) << match_addr);
            end
        end
    end

    // Iterator registers; address and valid are derived from the new mask.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            iter_mask   <= '0;
            match_addr  <= '0;
            match_valid <= 1'b0;
        end else if (iter_load) begin
            iter_mask   <= iter_src;
            match_addr  <= lowest_set(iter_src);
            match_valid <= |iter_src;
        end
    end

`ifdef TAG_RESOLVER_COUNT_EN

    localparam int unsigned IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    state_e                state;
    state_e                next_state;
    logic [DATA_DEPTH-1:0] snap;
    logic [IDX_W-1:0]      cnt_idx;
    logic [CNT_W-1:0]      acc;
    logic                  last_bit;

    assign last_bit = (cnt_idx == IDX_W'(DATA_DEPTH - 1));
    assign op_ready = (state == S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: COUNT lasts exactly DATA_DEPTH cycles.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && op == OP_COUNT) begin
                    next_state = S_COUNT;
                end
            end
            S_COUNT: begin
                if (last_bit) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Serial popcount: the snapshot shifts right so bit 0 is always the next row.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            snap        <= '0;
            cnt_idx     <= '0;
            acc         <= '0;
            match_count <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (state == S_IDLE && next_state == S_COUNT) begin
                snap    <= tag;
                cnt_idx <= '0;
                acc     <= '0;
            end else if (state == S_COUNT) begin
                snap    <= snap >> 1;
                cnt_idx <= cnt_idx + IDX_W'(1);
                acc     <= acc + CNT_W'(snap[0]);
                if (next_state == S_IDLE) begin
                    match_count <= acc + CNT_W'(snap[0]);
                    count_valid <= 1'b1;
                end
            end
        end
    end

`else

    assign op_ready    = 1'b1;
    assign match_count = CNT_W'(0);
    assign count_valid = 1'b0;

`endif

endmodule

// File: tb/tb_tag_resolver.sv
module tb_tag_resolver;

    localparam int unsigned DD = 16;
    localparam int unsigned AW = 8;

    localparam logic [2:0] NEXT  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] AND_  = 3'd2;
    localparam logic [2:0] OR_   = 3'd3;
    localparam logic [2:0] CLR   = 3'd4;
    localparam logic [2:0] SET   = 3'd5;
    localparam logic [2:0] FIRST = 3'd6;
    localparam logic [2:0] COUNT = 3'd7;

    logic          clk = 1'b0;
    logic          rstIn;
    logic [DD-1:0] tag_row;
    logic          op_valid;
    logic [2:0]    op;
    logic          op_ready;
    logic [DD-1:0] tag;
    logic          any_match;
    logic [AW-1:0] match_addr;
    logic          match_valid;
    logic [AW:0]   match_count;
    logic          count_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (behavioural, not cycle-structural).
    logic [DD-1:0] m_tag;
    logic [DD-1:0] m_mask;
    int unsigned   m_addr;
    logic          m_valid;
    int unsigned   m_count;
    logic          m_cv;
    int unsigned   m_busy;
    int unsigned   m_pending;

    always #5 clk = ~clk;

    tag_resolver #(
        .DATA_DEPTH    (DD),
        .ADDR_WIDTH_CAM(AW)
    ) dut (
        .clk        (clk),
        .rstIn      (rstIn),
        .tag_row    (tag_row),
        .op_valid   (op_valid),
        .op         (op),
        .op_ready   (op_ready),
        .tag        (tag),
        .any_match  (any_match),
        .match_addr (match_addr),
        .match_valid(match_valid),
        .match_count(match_count),
        .count_valid(count_valid)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int unsigned low_idx(input logic [DD-1:0] m);
        for (int i = 0; i < DD; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_tag     = '0;
        m_mask    = '0;
        m_addr    = 0;
        m_valid   = 1'b0;
        m_count   = 0;
        m_cv      = 1'b0;
        m_busy    = 0;
        m_pending = 0;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] o, input logic [DD-1:0] row);
        m_cv = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_count = m_pending;
                m_cv    = 1'b1;
            end
        end else if (v) begin
            case (o)
                LOAD:  m_tag = row;
                AND_:  m_tag = m_tag & row;
                OR_:   m_tag = m_tag | row;
                CLR:   m_tag = '0;
                SET:   m_tag = '1;
                FIRST: begin
                    m_mask  = m_tag;
                    m_valid = (m_mask != 0);
                    m_addr  = low_idx(m_mask);
                end
                NEXT: begin
                    if (m_valid) begin
                        m_mask[m_addr] = 1'b0;
                        m_valid = (m_mask != 0);
                        m_addr  = low_idx(m_mask);
                    end
                end
                default: begin
`ifdef TAG_RESOLVER_COUNT_EN
                    m_busy    = DD;
                    m_pending = $countones(m_tag);
`endif
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("tag",         32'(tag),         32'(m_tag));
        check("any_match",   32'(any_match),   32'(m_tag != 0));
        check("match_addr",  32'(match_addr),  m_addr);
        check("match_valid", 32'(match_valid), 32'(m_valid));
        check("match_count", 32'(match_count), m_count);
        check("count_valid", 32'(count_valid), 32'(m_cv));
        check("op_ready",    32'(op_ready),    32'(m_busy == 0));
    endtask

    // One clock cycle: drive on the falling edge, model the rising edge, sample after it.
    task automatic step(input logic v, input logic [2:0] o, input logic [DD-1:0] row);
        @(negedge clk);
        op_valid = v;
        op       = o;
        tag_row  = row;
        @(posedge clk);
        model_edge(v, o, row);
        #1;
        check_all();
    endtask

    // Asynchronous reset mid-cycle; released so the very next rising edge carries an op.
    task automatic apply_reset();
        @(negedge clk);
        rstIn    = 1'b1;
        op_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rstIn = 1'b0;
    endtask

    initial begin
        rstIn    = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        tag_row  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_ready", 32'(op_ready), 32'd1);
        #2;
        rstIn = 1'b0;

        // Set algebra.
        step(1'b1, LOAD, 16'h00A4);
        check("load_tag", 32'(tag), 32'h00A4);
        step(1'b1, AND_, 16'h0084);
        check("and_tag", 32'(tag), 32'h0084);
        step(1'b1, OR_, 16'h1000);
        check("or_tag", 32'(tag), 32'h1084);
        step(1'b1, CLR, 16'hFFFF);
        check("clr_any", 32'(any_match), 32'd0);
        step(1'b0, SET, 16'h0000);
        check("novalid_tag", 32'(tag), 32'd0);

        // Iterator walk.
        step(1'b1, LOAD, 16'h8012);
        step(1'b1, FIRST, 16'h0000);
        check("first_addr", 32'(match_addr), 32'd1);
        step(1'b1, LOAD, 16'h0F00);
        check("tagop_keeps_addr", 32'(match_addr), 32'd1);
        step(1'b1, NEXT, 16'h0000);
        check("next1_addr", 32'(match_addr), 32'd4);
        step(1'b1, NEXT, 16'h0000);
        check("next2_addr", 32'(match_addr), 32'd15);
        step(1'b1, NEXT, 16'h0000);
        check("next3_valid", 32'(match_valid), 32'd0);
        step(1'b1, NEXT, 16'h0000);
        check("next4_valid", 32'(match_valid), 32'd0);
        step(1'b1, CLR, 16'h0000);
        step(1'b1, FIRST, 16'h0000);
        check("first_empty", 32'(match_valid), 32'd0);

        // Full-width count with ignored ops while busy.
        step(1'b1, SET, 16'h0000);
        step(1'b1, COUNT, 16'h0000);
`ifdef TAG_RESOLVER_COUNT_EN
        check("count_busy", 32'(op_ready), 32'd0);
`else
        check("count_ready", 32'(op_ready), 32'd1);
`endif
        for (int k = 0; k < DD; k++) begin
            step(1'b1, 3'($urandom_range(0, 6)), DD'($urandom));
        end
`ifdef TAG_RESOLVER_COUNT_EN
        check("count_pulse", 32'(count_valid), 32'd1);
        check("count_value", 32'(match_count), 32'd16);
`else
        check("count_pulse", 32'(count_valid), 32'd0);
        check("count_value", 32'(match_count), 32'd0);
`endif
        step(1'b0, NEXT, 16'h0000);
        check("count_pulse_end", 32'(count_valid), 32'd0);

        // Reset during a count aborts it.
        step(1'b1, LOAD, 16'h0F0F);
        step(1'b1, COUNT, 16'h0000);
        for (int k = 0; k < 4; k++) step(1'b0, NEXT, 16'h0000);
        apply_reset();
        check("abort_ready", 32'(op_ready), 32'd1);
        check("abort_tag", 32'(tag), 32'd0);
        step(1'b1, LOAD, 16'h0003);
        check("post_rst_load", 32'(tag), 32'h0003);
        for (int k = 0; k < DD + 2; k++) step(1'b0, NEXT, 16'h0000);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [DD-1:0] row;
            row = ($urandom_range(0, 1) == 1) ? DD'($urandom) : DD'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 249) == 0) begin
                apply_reset();
            end
            step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), row);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
